thermo_sel_arbiter: RTL and testbench

Round-robin arbiter that turns four request lines into the 260-bit thermometer select code consumed by the downstream four-way output mux (codes 0x0, 0xF, 0xFF, 0xFFFF select inputs a, b, c, d). The downstream `case` has no default, so any code outside those four would silently hold its previous output. This block guarantees `sel` carries only a legal code from reset onward. It also holds each grant for a minimum dwell so the mux output does not toggle every cycle.

---
 rtl/thermo_sel_pkg.sv | 29 ++
 rtl/rr_pick4.sv | 27 ++
 rtl/thermo_sel_arbiter.sv | 105 ++++++++++
 tb/tb_thermo_sel_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/thermo_sel_pkg.sv
// Shared constants for the thermometer-select arbiter: select width, the four
// legal mux codes and the arbiter state encoding.
package thermo_sel_pkg;

    localparam int SEL_W = 260;

    localparam logic [SEL_W-1:0] SEL_CODE_A = '0;
    localparam logic [SEL_W-1:0] SEL_CODE_B = SEL_W'(16'h000F);
    localparam logic [SEL_W-1:0] SEL_CODE_C = SEL_W'(16'h00FF);
    localparam logic [SEL_W-1:0] SEL_CODE_D = SEL_W'(16'hFFFF);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Map a winner index onto its mux code; every index has a legal code.
    function automatic logic [SEL_W-1:0] sel_code(input logic [1:0] idx);
        logic [SEL_W-1:0] code;
        case (idx)
            2'd0:    code = SEL_CODE_A;
            2'd1:    code = SEL_CODE_B;
            2'd2:    code = SEL_CODE_C;
            default: code = SEL_CODE_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational cyclic priority picker: first set request bit scanning
// upward from ptr, wrapping at 3.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;
    logic       found;

    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/thermo_sel_arbiter.sv
// Round-robin arbiter producing the thermometer select code for the four-way
// output mux, with a minimum dwell per grant and an optional post-dwell freeze.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no grant; sel keeps its last legal code, waiting for req
//   ST_HOLD | grant active; cnt counts down the dwell, then re-arbitrate,
//           | freeze (lock) or release to IDLE
module thermo_sel_arbiter #(
    parameter int DWELL = 4,
    parameter int SEL_W = thermo_sel_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic             lock,
    output logic [SEL_W-1:0] sel,
    output logic [3:0]       grant,
    output logic             busy
);
    import thermo_sel_pkg::*;

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    state_t           state, state_nx;
    logic [1:0]       rr_ptr, rr_ptr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [SEL_W-1:0] sel_nx;
    logic [3:0]       grant_nx;
    logic             busy_nx;

    logic [1:0]       pick_idx;
    logic             pick_any;

    rr_pick4 u_pick (
        .req (req),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= 2'd0;
            cnt    <= '0;
            sel    <= SEL_CODE_A;
            grant  <= 4'b0000;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            rr_ptr <= rr_ptr_nx;
            cnt    <= cnt_nx;
            sel    <= sel_nx;
            grant  <= grant_nx;
            busy   <= busy_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        rr_ptr_nx = rr_ptr;
        cnt_nx    = cnt;
        sel_nx    = sel;
        grant_nx  = grant;
        busy_nx   = busy;

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nx  = ST_HOLD;
                    rr_ptr_nx = pick_idx + 2'd1;
                    cnt_nx    = CNT_LOAD;
                    sel_nx    = sel_code(pick_idx);
                    grant_nx  = 4'b0001 << pick_idx;
                    busy_nx   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (!lock) begin
                    // rr_ptr already points one past the outgoing winner.
                    if (pick_any) begin
                        rr_ptr_nx = pick_idx + 2'd1;
                        cnt_nx    = CNT_LOAD;
                        sel_nx    = sel_code(pick_idx);
                        grant_nx  = 4'b0001 << pick_idx;
                    end else begin
                        state_nx = ST_IDLE;
                        grant_nx = 4'b0000;
                        busy_nx  = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = 4'b0000;
                busy_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_thermo_sel_arbiter.sv
// Bench for thermo_sel_arbiter: DWELL=4 and DWELL=1 instances share stimulus,
// each compared every cycle against a grant-level reference model.
module tb_thermo_sel_arbiter;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         lock  = 1'b0;
    logic [3:0]   req   = 4'b0000;

    logic [259:0] sel4, sel1;
    logic [3:0]   grant4, grant1;
    logic         busy4, busy1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    thermo_sel_arbiter #(.DWELL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .sel(sel4), .grant(grant4), .busy(busy4)
    );

    thermo_sel_arbiter #(.DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .sel(sel1), .grant(grant1), .busy(busy1)
    );

    // Reference model: one entry per instance, tracked as "cycles left in grant".
    int m_dw[2] = '{4, 1};
    bit m_busy[2];
    int m_win[2];
    int m_ptr[2];
    int m_left[2];

    task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [259:0] code_of(input int w);
        logic [259:0] c;
        int nbits;
        c = '0;
        nbits = (w == 0) ? 0 : (4 << (w - 1));
        for (int i = 0; i < nbits; i++) c[i] = 1'b1;
        return c;
    endfunction

    function automatic int first_from(input int ptr, input logic [3:0] r);
        for (int k = 0; k < 4; k++)
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_busy[u] = 1'b0;
            m_win[u]  = 0;
            m_ptr[u]  = 0;
            m_left[u] = 0;
        end
    endtask

    task automatic model_step(input int u, input logic [3:0] r, input logic lk);
        int w;
        if (m_busy[u] && m_left[u] > 1) begin
            m_left[u]--;
        end else if (m_busy[u] && lk) begin
            // dwell expired but frozen
        end else begin
            w = first_from(m_ptr[u], r);
            if (w >= 0) begin
                m_busy[u] = 1'b1;
                m_win[u]  = w;
                m_ptr[u]  = (w + 1) % 4;
                m_left[u] = m_dw[u];
            end else begin
                m_busy[u] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [259:0] s;
        logic [3:0]   g;
        logic         b;
        bit           legal;
        for (int u = 0; u < 2; u++) begin
            s = (u == 0) ? sel4 : sel1;
            g = (u == 0) ? grant4 : grant1;
            b = (u == 0) ? busy4 : busy1;
            chk($sformatf("%s_d%0d_sel", tag, m_dw[u]), s, code_of(m_win[u]));
            chk($sformatf("%s_d%0d_grant", tag, m_dw[u]), 260'(g),
                m_busy[u] ? 260'(4'b0001 << m_win[u]) : 260'd0);
            chk($sformatf("%s_d%0d_busy", tag, m_dw[u]), 260'(b), 260'(m_busy[u]));
            legal = (s == code_of(0)) || (s == code_of(1)) ||
                    (s == code_of(2)) || (s == code_of(3));
            chk($sformatf("%s_d%0d_legal", tag, m_dw[u]), 260'(legal), 260'd1);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n)
            for (int u = 0; u < 2; u++) model_step(u, req, lock);
        @(negedge clk);
        check_all(tag);
    endtask

    // Called at a negedge; leaves rst_n high at the following negedge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, "_lit_sel"}, sel4, 260'd0);
        chk({tag, "_lit_grant"}, 260'(grant4), 260'd0);
        chk({tag, "_lit_busy"}, 260'(busy4), 260'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset("reset");

        // first grant one cycle after req
        req = 4'b0100;
        tick("first");
        chk("first_lit_grant", 260'(grant4), 260'(4'b0100));
        chk("first_lit_sel", sel4, 260'h00FF);
        chk("first_lit_busy", 260'(busy4), 260'd1);
        req = 4'b0000;
        repeat (5) tick("drain");

        // round robin over all four requesters, DWELL=4 cycles each
        @(negedge clk);
        do_reset("rst_rr");
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick("rr");
            chk($sformatf("rr_lit_grant_%0d", c), 260'(grant4), 260'(4'b0001 << ((c / 4) % 4)));
        end

        // early drop: grant in_b, then drop req
        @(negedge clk);
        do_reset("rst_drop");
        req = 4'b0010;
        tick("drop");
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick("drop");
            chk($sformatf("drop_lit_hold_%0d", c), 260'(grant4), 260'(4'b0010));
        end
        tick("drop");
        chk("drop_lit_idle_grant", 260'(grant4), 260'd0);
        chk("drop_lit_idle_sel", sel4, 260'h000F);
        chk("drop_lit_idle_busy", 260'(busy4), 260'd0);

        // lock during an in_d grant
        @(negedge clk);
        do_reset("rst_lock");
        req = 4'b1111;
        repeat (13) tick("lock_pre");
        chk("lock_lit_d", 260'(grant4), 260'(4'b1000));
        lock = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick("lock");
            chk($sformatf("lock_lit_grant_%0d", c), 260'(grant4), 260'(4'b1000));
            chk($sformatf("lock_lit_sel_%0d", c), sel4, 260'hFFFF);
        end
        lock = 1'b0;
        tick("unlock");
        chk("unlock_lit_grant", 260'(grant4), 260'(4'b0001));
        chk("unlock_lit_sel", sel4, 260'd0);

        // reset in cycle 2 of an in_c grant
        @(negedge clk);
        do_reset("rst_mid_pre");
        req = 4'b0100;
        tick("mid");
        tick("mid");
        chk("mid_lit_grant", 260'(grant4), 260'(4'b0100));
        do_reset("rst_mid");
        tick("mid_regrant");
        chk("mid_regrant_lit_grant", 260'(grant4), 260'(4'b0100));
        chk("mid_regrant_lit_sel", sel4, 260'h00FF);
        req = 4'b1111;
        repeat (4) tick("mid_ptr");
        chk("mid_ptr_lit_grant", 260'(grant4), 260'(4'b1000));

        // randomized stimulus, occasional reset
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd_rst");
            end else begin
                req  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
                lock = ($urandom_range(0, 3) == 0);
                tick("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
